// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants and FSM encoding for the fetch stage
package fetch_stage_pkg;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD = 32'h0;
  typedef enum logic [1:0] {F_RUN, F_DRAIN, F_DONE} fstate_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory bus between fetch (master) and memory (slave)
interface fetch_stage_if #(parameter int ADDR_W = 9);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_rdata;
  modport master(output imem_addr, input imem_rdata);
  modport slave(input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble insertion and hold
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        flashB
);
  always_ff @(posedge CLK) begin
    if (RST || bubble) begin
      instrD   <= NOP_WORD;
      pcPlus4D <= 32'h0;
      flashB   <= 1'b1;
    end else if (load) begin
      instrD   <= instr;
      pcPlus4D <= pc_plus4;
      flashB   <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC selection, halt drain FSM and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int IMEM_DEPTH   = 512,
  parameter int ADDR_W       = 9,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 stallF,
  input  logic                 branchTakenD,
  input  logic [31:0]          branchTargetD,
  input  logic                 jumpD,
  input  logic [31:0]          jAddrD,
  fetch_stage_if.master        imem,
  output logic [31:0]          pcF,
  output logic [31:0]          instrD,
  output logic [31:0]          pcPlus4D,
  output logic                 flashB,
  output logic                 done
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  fstate_t state;
  logic [CW-1:0] cnt;
  logic [31:0] pc_plus4;
  logic halt_hit, redirect, run, load, bubble;
  always_comb begin
    imem.imem_addr = pcF[ADDR_W+1:2];
    pc_plus4 = pcF + 32'd4;
    halt_hit = (imem.imem_rdata == HALT_WORD) || (pcF[31:2] >= 30'(IMEM_DEPTH));
    redirect = branchTakenD || jumpD;
    run = (state == F_RUN) && !stallF;
    load = run && !redirect && !halt_hit;
    bubble = (state != F_RUN) || (run && (redirect || halt_hit));
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcF   <= 32'h0;
      state <= F_RUN;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        F_RUN: if (!stallF) begin
          if (branchTakenD) pcF <= branchTargetD;
          else if (jumpD) pcF <= jAddrD;
          else if (halt_hit) begin
            state <= F_DRAIN;
            cnt   <= '0;
          end else pcF <= pc_plus4;
        end
        F_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DRAIN_CYCLES - 1)) state <= F_DONE;
        end
        default: done <= 1'b1;
      endcase
    end
  end
  if_id_reg u_if_id (
    .CLK(CLK),
    .RST(RST),
    .load(load),
    .bubble(bubble),
    .instr(imem.imem_rdata),
    .pc_plus4(pc_plus4),
    .instrD(instrD),
    .pcPlus4D(pcPlus4D),
    .flashB(flashB)
  );
endmodule
